// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction fetch sequencer for the single-cycle RV32I core. It owns the
//   PC, drives a combinational-read instruction memory (little-endian 4-byte
//   word, data valid in the same cycle as imem_req), and registers each
//   fetched word into a one-entry output stage that feeds decode.
//
//   Optional feature macro: IMEM_FETCH_PERF_EN adds the perf_fetch_cnt and
//   perf_stall_cnt outputs. Without it those ports and counters are absent.
//
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   fetch_en         1 = fetching permitted, 0 = pause (PC/output stage hold)
//   redirect_valid   branch/jump taken this cycle, target on redirect_pc
//   imem_req         memory read request (combinational from state)
//   imem_addr        memory byte address, always equal to the PC
//   imem_data        memory read data for imem_addr
//   inst_valid/ready output-stage handshake towards decode
//   inst_data/pc     fetched instruction word and its PC
//   fault            sticky fetch fault (misaligned or out-of-range PC)
//   fault_addr       offending PC
//   fsm_state        current FSM state (0 IDLE, 1 FETCH, 2 FAULT), debug
//   perf_fetch_cnt   (IMEM_FETCH_PERF_EN) cycles with imem_req=1
//   perf_stall_cnt   (IMEM_FETCH_PERF_EN) FETCH cycles stalled by decode
//
// Handshake: an instruction transfers to decode on every rising edge where
//   inst_valid=1 and inst_ready=1 and no redirect is asserted. Once inst_valid
//   is high, inst_data/inst_pc stay stable until that transfer happens; a
//   redirect flushes the held word instead of transferring it.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [1:0]  fsm_state
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Highest legal word address: 2**ADDR_WIDTH - 4.
  localparam logic [31:0] PC_MAX = 32'((64'd1 << ADDR_WIDTH) - 64'd4);

  state_t      state;
  logic [31:0] pc;
  logic        pc_legal;
  logic        fetch_go;

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= PC_MAX);
  endfunction

  assign pc_legal = is_legal(pc);

  // A fetch is attempted when enabled and the output stage is empty or is
  // being emptied this cycle. Redirect is excluded where it is used.
  assign fetch_go = fetch_en && (!inst_valid || inst_ready);

  assign imem_req  = (state == FETCH) && !redirect_valid && fetch_go && pc_legal;
  assign imem_addr = pc;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_data  <= 32'h0;
      inst_pc    <= 32'h0;
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else begin
      // Default: a handshake with no new fetch empties the stage.
      if (inst_valid && inst_ready) begin
        inst_valid <= 1'b0;
      end

      if (redirect_valid) begin
        // Redirect flushes whatever is held, even if decode is accepting it.
        inst_valid <= 1'b0;
        pc         <= redirect_pc;
        if (is_legal(redirect_pc)) begin
          state <= FETCH;
          fault <= 1'b0;
        end else begin
          state      <= FAULT;
          fault      <= 1'b1;
          fault_addr <= redirect_pc;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!pc_legal) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_addr <= pc;
              inst_valid <= 1'b0;
            end else if (fetch_en) begin
              state <= FETCH;
            end
          end

          FETCH: begin
            if (fetch_go) begin
              if (pc_legal) begin
                inst_data  <= imem_data;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                pc         <= pc + 32'd4;
              end else begin
                // The fault is taken only once the held word has been
                // accepted (fetch_go), so the last legal word is delivered.
                state      <= FAULT;
                fault      <= 1'b1;
                fault_addr <= pc;
                inst_valid <= 1'b0;
              end
            end
          end

          FAULT: begin
            inst_valid <= 1'b0;
            fault      <= 1'b1;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (imem_req) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if ((state == FETCH) && inst_valid && !inst_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Self-checking bench for imem_fetch_ctrl (ADDR_WIDTH=7). A behavioural
//   128-byte memory answers imem_addr combinationally. Expected instruction
//   PCs are pushed into exp_q as stimulus is driven; every accepted
//   instruction is popped and its PC and data compared against the memory.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fault_addr;
  logic [1:0]  fsm_state;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [31:0] mem [0:31];
  logic [31:0] exp_q [$];
  logic [31:0] sb_exp;
  int          n_checks;
  int          n_fail;
  int          bad_req;
  logic        done;

  imem_fetch_ctrl #(.ADDR_WIDTH(7), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .fsm_state      (fsm_state)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Combinational memory; out-of-range addresses return a marker word.
  assign imem_data = (imem_addr < 32'h80) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_range(input logic [31:0] first, input logic [31:0] last);
    for (logic [32:0] a = {1'b0, first}; a <= {1'b0, last}; a = a + 33'd4) begin
      exp_q.push_back(a[31:0]);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_inst", inst_pc, 32'hFFFF_FFFF);
      end else begin
        sb_exp = exp_q.pop_front();
        check_eq("sb_pc", inst_pc, sb_exp);
        check_eq("sb_data", inst_data, mem[sb_exp[6:2]]);
      end
    end
    if (rst_n && imem_req && !((imem_addr <= 32'h7C) && (imem_addr[1:0] == 2'b00))) begin
      bad_req++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks       = 0;
    n_fail         = 0;
    bad_req        = 0;
    done           = 1'b0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom_range(32'hFFFF_FFFF, 0);

    // Reset state.
    next_cycle();
    next_cycle();
    sample();
    check_eq("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check_eq("rst_inst_data", inst_data, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_fault", {31'h0, fault}, 32'h0);
    check_eq("rst_fault_addr", fault_addr, 32'h0);
    check_eq("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check_eq("rst_imem_addr", imem_addr, 32'h0);
`ifdef IMEM_FETCH_PERF_EN
    check_eq("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check_eq("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif

    // Streaming fetch of W0..W3: request in cycle 2, valid from cycle 3.
    next_cycle();
    rst_n      = 1'b1;
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    push_range(32'h00, 32'h0C);
    sample();
    check_eq("idle_no_req", {31'h0, imem_req}, 32'h0);
    next_cycle();
    sample();
    check_eq("first_req", {31'h0, imem_req}, 32'h1);
    check_eq("first_addr", imem_addr, 32'h0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("stream_valid", {31'h0, inst_valid}, 32'h1);
      check_eq("stream_pc", inst_pc, 32'(i * 4));
      next_cycle();
      if (i == 2) fetch_en = 1'b0;
    end
    sample();
    check_eq("drain_empty", {31'h0, inst_valid}, 32'h0);

    // Back-pressure with inst_pc=0x04 held for 3 cycles.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h04;
    next_cycle();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    exp_q.push_back(32'h04);
    sample();
    check_eq("stall_pre_addr", imem_addr, 32'h04);
    next_cycle();
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq("stall_req", {31'h0, imem_req}, 32'h0);
      check_eq("stall_valid", {31'h0, inst_valid}, 32'h1);
      check_eq("stall_pc", inst_pc, 32'h04);
      check_eq("stall_data", inst_data, mem[1]);
      next_cycle();
    end
    inst_ready = 1'b1;
    sample();
    check_eq("resume_req", {31'h0, imem_req}, 32'h1);
    check_eq("resume_addr", imem_addr, 32'h08);

    // Redirect to 0x40 while a word is valid and accepted: it is flushed.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    sample();
    check_eq("redirect_no_req", {31'h0, imem_req}, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    exp_q.push_back(32'h40);
    sample();
    check_eq("redirect_flush", {31'h0, inst_valid}, 32'h0);
    check_eq("redirect_addr", imem_addr, 32'h40);
    next_cycle();
    fetch_en = 1'b0;
    sample();
    check_eq("redirect_valid_pc", inst_pc, 32'h40);

    // Illegal redirect target 0x42 -> sticky fault, then recover at 0x10.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    fetch_en       = 1'b1;
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq("fault_set", {31'h0, fault}, 32'h1);
      check_eq("fault_addr_42", fault_addr, 32'h42);
      check_eq("fault_no_req", {31'h0, imem_req}, 32'h0);
      check_eq("fault_no_valid", {31'h0, inst_valid}, 32'h0);
      next_cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    next_cycle();
    redirect_valid = 1'b0;
    push_range(32'h10, 32'h7C);
    sample();
    check_eq("recover_fault", {31'h0, fault}, 32'h0);
    check_eq("recover_req", {31'h0, imem_req}, 32'h1);
    check_eq("recover_addr", imem_addr, 32'h10);

    // Sequential fetch through 0x7C, then range fault at 0x80.
    for (int t = 0; t < 100 && !done; t++) begin
      next_cycle();
      sample();
      if (fault) done = 1'b1;
    end
    check_eq("top_fault_seen", {31'h0, done}, 32'h1);
    check_eq("top_fault_addr", fault_addr, 32'h80);
    check_eq("top_no_req", {31'h0, imem_req}, 32'h0);
    check_eq("top_sb_drained", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of a stall discards the held word.
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle();
    sample();
    check_eq("prerst_valid", {31'h0, inst_valid}, 32'h1);
    check_eq("prerst_pc", inst_pc, 32'h0);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    push_range(32'h00, 32'h04);
    sample();
    check_eq("midrst_valid", {31'h0, inst_valid}, 32'h0);
    check_eq("midrst_addr", imem_addr, 32'h0);
    check_eq("midrst_fault", {31'h0, fault}, 32'h0);
`ifdef IMEM_FETCH_PERF_EN
    check_eq("midrst_perf_fetch", perf_fetch_cnt, 32'h0);
    check_eq("midrst_perf_stall", perf_stall_cnt, 32'h0);
`endif
    next_cycle();
    sample();
    check_eq("refetch_req", {31'h0, imem_req}, 32'h1);
    check_eq("refetch_addr", imem_addr, 32'h0);
    next_cycle();
    next_cycle();
    fetch_en = 1'b0;
    next_cycle();
    sample();
    check_eq("final_empty", {31'h0, inst_valid}, 32'h0);
    check_eq("final_sb_drained", 32'(exp_q.size()), 32'h0);
    check_eq("no_illegal_req", 32'(bad_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the byte-addressed instruction memory (little-endian 4-byte read, combinational `imem_data`) for the single-cycle RV32I core.
- Owns the PC, drives `imem_req`/`imem_addr`, and registers each fetched word into a one-entry valid/ready output stage feeding decode.
- Handles back-pressure, branch/jump redirects, fetch enable, and misaligned or out-of-range fetch faults.

Parameters:
- ADDR_WIDTH, 7: instruction memory byte-address width (2**ADDR_WIDTH bytes).
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- fetch_en  in  1  1 = fetching permitted; 0 = pause (PC and output stage hold).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  new PC target.
- imem_req  out  1  memory read request (combinational from state).
- imem_addr  out  32  memory byte address = pc.
- imem_data  in  32  memory read data, valid in the same cycle as imem_req.
- inst_valid  out  1  output stage holds an instruction.
- inst_ready  in  1  decode accepts the instruction.
- inst_data  out  32  fetched instruction.
- inst_pc  out  32  PC of inst_data.
- fault  out  1  sticky fetch fault.
- fault_addr  out  32  offending PC.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, state=IDLE.
  - inst_valid=0, inst_data=0, inst_pc=0, fault=0, fault_addr=0.
  - imem_req=0, imem_addr=RESET_PC.
- Reset mid-operation discards the held instruction; no partial state survives.
- States:
  - IDLE: imem_req=0. Next cycle goes to FETCH if fetch_en=1 and pc is legal; goes to FAULT if pc is illegal.
  - FETCH: fetch condition = fetch_en & !redirect_valid & (!inst_valid | inst_ready).
    - When the condition holds: imem_req=1, imem_addr=pc.
    - At the posedge: inst_data<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
    - Latency: address to inst_valid = 1 cycle. Sustained throughput = 1 instruction/cycle with inst_ready held 1.
    - inst_valid & !inst_ready: imem_req=0; pc, inst_data and inst_pc hold (valid/data stable until accepted).
    - Handshake with no new fetch clears inst_valid.
    - fetch_en=0: imem_req=0; the output stage may still drain on inst_ready.
  - FAULT: imem_req=0, inst_valid=0, fault=1, fault_addr latched. Exit only via reset or a redirect with a legal target.
- Legality: pc[1:0]==0 and pc <= 2**ADDR_WIDTH-4 (0x7C at default width).
  - Entering FETCH with an illegal pc goes to FAULT with no request.
  - After pc<=pc+4 overruns the top of memory, the next cycle goes to FAULT with fault_addr = 2**ADDR_WIDTH.
- Redirect (priority over everything except reset):
  - Same cycle: imem_req=0.
  - Posedge: inst_valid<=0 (held or in-flight instruction flushed, even if inst_ready=1), pc<=redirect_pc.
  - Legal target: state=FETCH, fault cleared, first fetch on the next cycle (1-cycle bubble).
  - Illegal target: state=FAULT, fault_addr<=redirect_pc.
- PC arithmetic: 32-bit modulo 2**32. The wrap is always caught by the range check first.
- imem_addr equals pc in all states.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every imem_req=1 cycle.
  - perf_stall_cnt increments on every FETCH-state cycle with inst_valid & !inst_ready.
  - Both wrap at 2**32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then fetch_en=1, inst_ready=1, memory words W0..W3 at 0x00..0x0C -> imem_req first high in cycle 2; inst_valid from cycle 3 with inst_pc 0x00, 0x04, 0x08, 0x0C and inst_data W0..W3 in consecutive cycles.
- inst_ready=0 for 3 cycles while inst_valid with inst_pc=0x04 -> imem_req=0, inst_data/inst_pc stable 3 cycles; on inst_ready=1, next inst_pc=0x08 with no skipped or duplicated word.
- redirect_valid=1, redirect_pc=0x40 while inst_valid=1 and inst_ready=1 -> inst_valid=0 next cycle; next valid inst_pc=0x40 one cycle later.
- redirect_pc=0x42 -> fault=1, fault_addr=0x42, imem_req=0 persistently; then redirect_pc=0x10 -> fault=0, fetch resumes with inst_pc=0x10.
- Fetch sequentially to 0x7C (ADDR_WIDTH=7) -> word at 0x7C delivered, then fault=1, fault_addr=0x80, no request at 0x80.
- rst_n=0 for one cycle mid-stall with inst_valid=1 -> inst_valid=0, pc=RESET_PC; refetch starts from 0x00. With IMEM_FETCH_PERF_EN, counters read 0.
